uart_tx_sched: RTL and testbench

Byte scheduler that shares the single bus-attached UART transmitter among `N_REQ` on-chip requesters (CPU shim, debug monitor, log engine). It owns the UART's slave port on the high-speed bus side. It round-robin arbitrates between requesters and polls the UART status register until `tx_ready` is set. It then writes the granted byte to the TX data register. Multi-byte messages can hold the grant (packet lock) so bytes from different requesters never interleave.

---
 rtl/uart_tx_sched.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_sched.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Shares one bus-attached UART transmitter among N_REQ requesters (round-robin, packet lock).
// Latency: pop to uart_wen in 3 cycles on an idle UART; each failed status poll adds 2+POLL_GAP cycles.
// Backpressure: a requester holds req_valid until its one-hot req_ready pop; a locked message blocks the others.
module uart_tx_sched #(
  parameter int N_REQ        = 4,
  parameter int POLL_GAP     = 16,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic               hb_clk,
  input  logic               hb_rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ-1:0]   req_last,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               uart_ren,
  output logic               uart_wen,
  output logic [4:0]         uart_addr,
  output logic [31:0]        uart_wdata,
  input  logic [31:0]        uart_rdata,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic [15:0]        sent_cnt
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam int TW = $clog2(LOCK_TIMEOUT);

  localparam logic [GW-1:0] GAP_LOAD    = GW'(POLL_GAP - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(LOCK_TIMEOUT - 1);
  localparam logic [4:0]    ADDR_STATUS = 5'd0;
  localparam logic [4:0]    ADDR_TXDATA = 5'd28;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_POLL   = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_LOCKED = 3'd5;

  logic [2:0]    state;
  logic [IW-1:0] rr;
  logic [IW-1:0] grant_idx;
  logic [IW-1:0] next_rr;
  logic [7:0]    byte_q;
  logic          last_q;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] to_cnt;

  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] cand;
  logic          lock_vld;
  logic          unused_rdata;

  // Only tx_ready (bit 0) of the status word matters.
  assign unused_rdata = ^uart_rdata[31:1];

  function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // First valid requester searching rr, rr+1, ... modulo N_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IW'((int'(rr) + k) % N_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign next_rr  = IW'((int'(grant_idx) + 1) % N_REQ);
  assign lock_vld = req_valid[grant_idx];

  always_ff @(posedge hb_clk or negedge hb_rst_n) begin
    if (!hb_rst_n) begin
      state     <= S_IDLE;
      rr        <= '0;
      grant     <= '0;
      grant_idx <= '0;
      byte_q    <= '0;
      last_q    <= 1'b0;
      gap_cnt   <= '0;
      to_cnt    <= '0;
      sent_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_found) begin
            byte_q    <= req_data[{win_idx, 3'b000} +: 8];
            last_q    <= req_last[win_idx];
            grant     <= onehot(win_idx);
            grant_idx <= win_idx;
            state     <= S_POLL;
          end
        end
        S_POLL: state <= S_CHECK;
        S_CHECK: begin
          if (uart_rdata[0]) begin
            state <= S_WRITE;
          end else begin
            gap_cnt <= GAP_LOAD;
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) begin
            state <= S_POLL;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        S_WRITE: begin
          sent_cnt <= sent_cnt + 16'd1;
          if (last_q) begin
            rr    <= next_rr;
            grant <= '0;
            state <= S_IDLE;
          end else begin
            to_cnt <= '0;
            state  <= S_LOCKED;
          end
        end
        S_LOCKED: begin
          // Only the lock owner may continue; the lock lasts LOCK_TIMEOUT idle cycles at most.
          if (lock_vld) begin
            byte_q <= req_data[{grant_idx, 3'b000} +: 8];
            last_q <= req_last[grant_idx];
            state  <= S_POLL;
          end else if (to_cnt == TO_LAST) begin
            rr    <= next_rr;
            grant <= '0;
            state <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The pop in IDLE is combinational on req_valid, so it is held off while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && win_found && hb_rst_n) begin
      req_ready = onehot(win_idx);
    end else if (state == S_LOCKED && lock_vld) begin
      req_ready = onehot(grant_idx);
    end
  end

  assign uart_ren   = (state == S_POLL);
  assign uart_wen   = (state == S_WRITE);
  assign uart_addr  = (state == S_WRITE) ? ADDR_TXDATA : ADDR_STATUS;
  assign uart_wdata = (state == S_WRITE) ? {24'b0, byte_q} : 32'b0;
  assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: cycle table for a single byte, then sequences for
// busy UART, packet lock, lock timeout, round-robin and reset in the middle of a poll gap.
module tb_uart_tx_sched;

  localparam int N        = 4;
  localparam int BUSY_CYC = 2;
  localparam int HIST     = 4096;

  logic        hb_clk   = 1'b0;
  logic        hb_rst_n = 1'b1;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        uart_ren;
  logic        uart_wen;
  logic [4:0]  uart_addr;
  logic [31:0] uart_wdata;
  logic [31:0] uart_rdata = '0;
  logic [3:0]  grant;
  logic        busy;
  logic [15:0] sent_cnt;

  always #5 hb_clk = ~hb_clk;

  uart_tx_sched #(.N_REQ(N), .POLL_GAP(4), .LOCK_TIMEOUT(8)) dut (
    .hb_clk    (hb_clk),
    .hb_rst_n  (hb_rst_n),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .uart_ren  (uart_ren),
    .uart_wen  (uart_wen),
    .uart_addr (uart_addr),
    .uart_wdata(uart_wdata),
    .uart_rdata(uart_rdata),
    .grant     (grant),
    .busy      (busy),
    .sent_cnt  (sent_cnt)
  );

  // UART slave model: registered status read, busy for BUSY_CYC cycles after each write,
  // plus forced not-ready answers while poll_cnt < stall_until. Upper bits carry junk.
  int busy_cnt    = 0;
  int poll_cnt    = 0;
  int stall_until = 0;
  always @(posedge hb_clk) begin
    if (uart_ren) begin
      if (poll_cnt < stall_until || busy_cnt != 0) uart_rdata <= 32'hA5A5_A5A4;
      else                                         uart_rdata <= 32'hA5A5_A5A5;
      poll_cnt <= poll_cnt + 1;
    end
    if (uart_wen)           busy_cnt <= BUSY_CYC;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic [63:0] exp;
  } vec_t;

  vec_t        tbl[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  logic [3:0]  grant_hist[HIST];
  logic [3:0]  ready_hist[HIST];
  int          ren_q[$];
  int          wen_q[$];
  logic [7:0]  wr_q[$];
  logic [7:0]  exp_q[$];
  logic [8:0]  rmem[4][8];
  int          rhead[4];
  int          rtail[4];

  function automatic logic [63:0] outs();
    return {req_ready, uart_ren, uart_wen, uart_addr, uart_wdata, grant, busy, sent_cnt};
  endfunction

  function automatic logic [63:0] mk(input logic [3:0] rdy, input logic ren, input logic wen,
                                     input logic [4:0] addr, input logic [31:0] wd,
                                     input logic [3:0] g, input logic b, input logic [15:0] s);
    return {rdy, ren, wen, addr, wd, g, b, s};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                         input logic [63:0] e);
    vec_t t;
    t.valid = v; t.last = l; t.data = d; t.exp = e;
    tbl.push_back(t);
  endtask

  task automatic push(input int i, input logic last, input logic [7:0] d);
    rmem[i][rtail[i] % 8] = {last, d};
    rtail[i]++;
  endtask

  task automatic drive();
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    logic [8:0]  e;
    v = '0; l = '0; d = '0;
    for (int i = 0; i < N; i++) begin
      if (rhead[i] != rtail[i]) begin
        e           = rmem[i][rhead[i] % 8];
        v[i]        = 1'b1;
        l[i]        = e[8];
        d[8*i +: 8] = e[7:0];
      end
    end
    req_valid = v; req_last = l; req_data = d;
  endtask

  // One clock: sample at negedge, then advance requester FIFOs on pops just after posedge.
  task automatic cycle();
    logic [3:0] rs;
    @(negedge hb_clk);
    rs = req_ready;
    if (cyc < HIST) begin
      grant_hist[cyc] = grant;
      ready_hist[cyc] = req_ready;
    end
    if (uart_ren) ren_q.push_back(cyc);
    if (uart_wen) begin
      wen_q.push_back(cyc);
      wr_q.push_back(uart_wdata[7:0]);
    end
    if (uart_ren && uart_wen) begin
      n_vec++; n_bad++;
      $display("FAIL ren_wen_overlap: both strobes high at cycle %0d, required at most one", cyc);
    end
    @(posedge hb_clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) if (rs[i] && rhead[i] != rtail[i]) rhead[i]++;
    drive();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic clear_logs();
    ren_q.delete(); wen_q.delete(); wr_q.delete(); exp_q.delete();
  endtask

  task automatic run_writes(input string name, input int n, input int budget);
    int k;
    k = 0;
    while (wr_q.size() < n && k < budget) begin
      cycle();
      k++;
    end
    chk({name, "_write_count"}, 64'(wr_q.size()), 64'(n));
  endtask

  task automatic check_order(input string name);
    for (int k = 0; k < exp_q.size(); k++)
      if (k < wr_q.size()) chk($sformatf("%s_byte%0d", name, k), 64'(wr_q[k]), 64'(exp_q[k]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int k;
    logic [3:0] acc;
    for (int i = 0; i < N; i++) begin rhead[i] = 0; rtail[i] = 0; end

    // Reset state, with every requester offering a byte: nothing may be popped.
    req_valid = 4'hF; req_last = 4'hF; req_data = 32'h0403_0201;
    #2 hb_rst_n = 1'b0;
    repeat (2) @(posedge hb_clk);
    #1;
    chk("reset_outputs", outs(), 64'd0);
    req_valid = '0; req_last = '0; req_data = '0;
    hb_rst_n  = 1'b1;

    // Single byte from req2 on an idle UART, then req0+req3 contend with rr=3.
    add_vec(4'b0100, 4'b0100, 32'h0055_0000, mk(4'b0100, 0, 0, 5'd0,  32'h00, 4'b0000, 0, 16'd0));
    add_vec(4'b0000, 4'b0000, 32'h0,         mk(4'b0000, 1, 0, 5'd0,  32'h00, 4'b0100, 1, 16'd0));
    add_vec(4'b0000, 4'b0000, 32'h0,         mk(4'b0000, 0, 0, 5'd0,  32'h00, 4'b0100, 1, 16'd0));
    add_vec(4'b0000, 4'b0000, 32'h0,         mk(4'b0000, 0, 1, 5'd28, 32'h55, 4'b0100, 1, 16'd0));
    add_vec(4'b0000, 4'b0000, 32'h0,         mk(4'b0000, 0, 0, 5'd0,  32'h00, 4'b0000, 0, 16'd1));
    add_vec(4'b1001, 4'b1001, 32'h3300_0011, mk(4'b1000, 0, 0, 5'd0,  32'h00, 4'b0000, 0, 16'd1));
    add_vec(4'b0001, 4'b0001, 32'h0000_0011, mk(4'b0000, 1, 0, 5'd0,  32'h00, 4'b1000, 1, 16'd1));
    add_vec(4'b0001, 4'b0001, 32'h0000_0011, mk(4'b0000, 0, 0, 5'd0,  32'h00, 4'b1000, 1, 16'd1));
    add_vec(4'b0001, 4'b0001, 32'h0000_0011, mk(4'b0000, 0, 1, 5'd28, 32'h33, 4'b1000, 1, 16'd1));
    add_vec(4'b0000, 4'b0000, 32'h0,         mk(4'b0000, 0, 0, 5'd0,  32'h00, 4'b0000, 0, 16'd2));
    for (int i = 0; i < tbl.size(); i++) begin
      req_valid = tbl[i].valid; req_last = tbl[i].last; req_data = tbl[i].data;
      @(negedge hb_clk);
      chk($sformatf("table_vec%0d", i), outs(), tbl[i].exp);
      @(posedge hb_clk);
      #1;
    end
    drive();

    // Packet lock: req1 takes the grant first, req0/req2 arrive while it is locked.
    idle(5); clear_logs();
    push(1, 1'b0, 8'hA1); push(1, 1'b0, 8'hA2); push(1, 1'b1, 8'hA3);
    drive(); cycle();
    push(0, 1'b1, 8'hB0); push(2, 1'b1, 8'hC2); drive();
    run_writes("lock", 5, 400);
    exp_q = '{8'hA1, 8'hA2, 8'hA3, 8'hC2, 8'hB0};
    check_order("lock");

    // Busy UART: two not-ready answers with POLL_GAP=4, polls every 2+4 cycles.
    idle(5); clear_logs();
    stall_until = poll_cnt + 2;
    push(1, 1'b1, 8'h5A); drive();
    run_writes("busy", 1, 200);
    idle(6);
    chk("busy_ren_count", 64'(ren_q.size()), 64'd3);
    chk("busy_wen_count", 64'(wen_q.size()), 64'd1);
    if (ren_q.size() == 3 && wen_q.size() == 1) begin
      chk("busy_poll_gap1", 64'(ren_q[1] - ren_q[0]), 64'd6);
      chk("busy_poll_gap2", 64'(ren_q[2] - ren_q[1]), 64'd6);
      chk("busy_poll_to_write", 64'(wen_q[0] - ren_q[2]), 64'd2);
    end
    exp_q = '{8'h5A};
    check_order("busy");

    // Lock timeout: req1 sends a non-last byte then goes quiet; LOCKED lasts 8 cycles.
    idle(5); clear_logs();
    push(1, 1'b0, 8'hB1); drive(); cycle();
    push(0, 1'b1, 8'hC0); push(2, 1'b1, 8'hC2); drive();
    run_writes("timeout", 3, 400);
    exp_q = '{8'hB1, 8'hC2, 8'hC0};
    check_order("timeout");
    if (wen_q.size() > 0 && wen_q[0] + 9 < HIST) begin
      w = wen_q[0]; k = 0; acc = '0;
      while (k < 20 && grant_hist[w + 1 + k] == 4'b0010) k++;
      for (int j = 1; j <= 8; j++) acc = acc | ready_hist[w + j];
      chk("timeout_hold_cycles", 64'(k), 64'd8);
      chk("timeout_grant_cleared", 64'(grant_hist[w + 9]), 64'd0);
      chk("timeout_no_preempt", 64'(acc), 64'd0);
    end

    // Reset during GAP; afterwards round-robin restarts at req0 and 0x77 is lost.
    idle(5); clear_logs();
    stall_until = poll_cnt + 1000;
    push(1, 1'b1, 8'h77); drive();
    k = 0;
    while (ren_q.size() == 0 && k < 100) begin cycle(); k++; end
    chk("rst_seq_poll_seen", 64'(ren_q.size()), 64'd1);
    cycle(); cycle();
    chk("rst_seq_in_gap_busy", 64'(busy), 64'd1);
    stall_until = poll_cnt;
    for (int i = 0; i < N; i++) push(i, 1'b1, 8'(8'h10 + i));
    for (int i = 0; i < N; i++) push(i, 1'b1, 8'(8'h20 + i));
    drive();
    hb_rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", outs(), 64'd0);
    @(posedge hb_clk);
    #1;
    hb_rst_n = 1'b1;
    chk("rst_sent_cnt_cleared", 64'(sent_cnt), 64'd0);
    clear_logs();
    run_writes("rr", 8, 800);
    for (int i = 0; i < N; i++) exp_q.push_back(8'(8'h10 + i));
    for (int i = 0; i < N; i++) exp_q.push_back(8'(8'h20 + i));
    check_order("rr");
    chk("rr_sent_cnt", 64'(sent_cnt), 64'd8);
    idle(40);
    chk("rst_discarded_never_written", 64'(wr_q.size()), 64'd8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
